// File: rtl/fwvip_wb_target_mem_if.sv
// Wishbone classic bus bundle between one master and the target memory.
interface fwvip_wb_target_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;

  modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack, err);
  modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack, err);
endinterface

// File: rtl/fwvip_wb_target_mem.sv
// Wishbone target backed by a DEPTH-word memory with programmable wait states.
// A request is captured in IDLE, spends WAIT_STATES+1 cycles in WAIT (so the
// termination lands in the cycle after edge N+1+WAIT_STATES), then terminates
// for exactly one cycle in RESP. Dropping cyc while in WAIT aborts the transfer.
// Optional macro FWVIP_WB_TARGET_MEM_ERR_EN: word indices >= DEPTH end with err
// instead of wrapping modulo DEPTH.
module fwvip_wb_target_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic                  clock,
  input logic                  reset,
  fwvip_wb_target_mem_if.slave bus
);
  localparam int SEL_W     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(SEL_W);
  localparam int IDX_W     = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [SEL_W-1:0]      sel;
    logic [DATA_WIDTH-1:0] dat;
    logic [IDX_W-1:0]      idx;
    logic                  oob;
  } req_t;

  state_t                state, state_nxt;
  req_t                  req;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dat_r_q;
  logic                  accept, commit, oob_in;
  logic                  unused_adr;

`ifdef FWVIP_WB_TARGET_MEM_ERR_EN
  assign oob_in = |bus.adr[ADDR_WIDTH-1:LANE_BITS+IDX_W];
`else
  assign oob_in = 1'b0;
`endif
  // byte-offset bits (and, when wrapping, the upper bits) are don't-care
  assign unused_adr = ^bus.adr;

  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  // next-state: abort only on cyc low; stb alone never starts a transfer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cyc && bus.stb) state_nxt = WAIT;
      WAIT:    if (!bus.cyc) state_nxt = IDLE;
               else if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: termination is a pure function of being in RESP
  always_comb begin
    accept = (state == IDLE) && bus.cyc && bus.stb;
    commit = (state == WAIT) && bus.cyc && (cnt == 4'd0);
  end
  assign bus.ack   = (state == RESP) && !req.oob;
  assign bus.err   = (state == RESP) &&  req.oob;
  assign bus.dat_r = dat_r_q;

  // capture request and run the wait-state down-counter
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      req <= '0;
      cnt <= '0;
    end else if (accept) begin
      req.we  <= bus.we;
      req.sel <= bus.sel;
      req.dat <= bus.dat_w;
      req.idx <= bus.adr[LANE_BITS +: IDX_W];
      req.oob <= oob_in;
      cnt     <= 4'(WAIT_STATES);
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end

  // storage: no reset, lane-masked write on the edge entering RESP
  always_ff @(posedge clock)
    if (commit && req.we && !req.oob)
      for (int i = 0; i < SEL_W; i++)
        if (req.sel[i]) mem[req.idx][8*i +: 8] <= req.dat[8*i +: 8];

  // read data: loaded on the edge entering RESP, held otherwise
  always_ff @(posedge clock or negedge reset)
    if (!reset) dat_r_q <= '0;
    else if (commit) begin
      if (req.oob)     dat_r_q <= '0;
      else if (!req.we) dat_r_q <= mem[req.idx];
    end
endmodule

// File: tb/tb_fwvip_wb_target_mem.sv
// Bench for fwvip_wb_target_mem: one instance with no wait states, one with
// three, sharing master signals; cyc/stb are steered to the selected target.
module tb_fwvip_wb_target_mem;
  logic        clock = 0;
  logic        reset = 0;
  logic [31:0] adr = 0, dat_w = 0;
  logic        we = 0, stb = 0, cyc = 0;
  logic [3:0]  sel = 0;
  int          tgt = 0;
  int          n_checks = 0, n_errors = 0;
  logic [31:0] model [2][256];

  always #5 clock = ~clock;

  fwvip_wb_target_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  fwvip_wb_target_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  assign bus0.adr = adr;  assign bus0.dat_w = dat_w; assign bus0.we = we; assign bus0.sel = sel;
  assign bus1.adr = adr;  assign bus1.dat_w = dat_w; assign bus1.we = we; assign bus1.sel = sel;
  assign bus0.cyc = cyc && (tgt == 0);  assign bus0.stb = stb && (tgt == 0);
  assign bus1.cyc = cyc && (tgt == 1);  assign bus1.stb = stb && (tgt == 1);

  wire        ack_o  = (tgt == 1) ? bus1.ack   : bus0.ack;
  wire        err_o  = (tgt == 1) ? bus1.err   : bus0.err;
  wire [31:0] dat_r_o = (tgt == 1) ? bus1.dat_r : bus0.dat_r;

  fwvip_wb_target_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));
  fwvip_wb_target_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  // reference: word index is the byte address divided by 4
  function automatic bit is_oob(input logic [31:0] a);
`ifdef FWVIP_WB_TARGET_MEM_ERR_EN
    return (a / 4) >= 256;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  function automatic int exp_lat(input int t);
    return 2 + (t == 1 ? 3 : 0);
  endfunction

  task automatic model_write(input int t, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (is_oob(a)) return;
    w = model[t][widx(a)];
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[t][widx(a)] = w;
  endtask

  // one transfer; lat counts negedges after the sampling edge until termination
  task automatic xfer(input int t, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output bit ak, output bit er,
                      output logic [31:0] rd, output bit both);
    @(negedge clock);
    tgt = t; we = w; adr = a; dat_w = d; sel = s; cyc = 1; stb = 1;
    lat = 40; ak = 0; er = 0; rd = '0; both = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (ack_o && err_o) both = 1;
      if (ack_o || err_o) begin
        lat = i; ak = ack_o; er = err_o; rd = dat_r_o;
        break;
      end
    end
    cyc = 0; stb = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clock);
    for (int t = 0; t < 2; t++) begin
      tgt = t; #1;
      n_checks++; if (ack_o !== 1'b0) begin n_errors++; $display("FAIL reset_ack t%0d got=%b exp=0", t, ack_o); end
      n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err t%0d got=%b exp=0", t, err_o); end
      n_checks++; if (dat_r_o !== 32'h0) begin n_errors++; $display("FAIL reset_dat_r t%0d got=%h exp=0", t, dat_r_o); end
    end
    @(negedge clock); reset = 1; tgt = 0;
  endtask

  task automatic test_basic();
    int lat; bit ak, er, both; logic [31:0] rd;
    for (int t = 0; t < 2; t++) begin
      xfer(t, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, ak, er, rd, both);
      model_write(t, 32'h10, 32'hDEADBEEF, 4'hF);
      n_checks++; if (!ak || er || lat != exp_lat(t)) begin n_errors++;
        $display("FAIL basic_wr t%0d got ack=%b err=%b lat=%0d exp ack=1 err=0 lat=%0d", t, ak, er, lat, exp_lat(t)); end
      xfer(t, 0, 32'h10, 32'h0, 4'hF, lat, ak, er, rd, both);
      n_checks++; if (!ak || er || lat != exp_lat(t)) begin n_errors++;
        $display("FAIL basic_rd t%0d got ack=%b err=%b lat=%0d exp ack=1 err=0 lat=%0d", t, ak, er, lat, exp_lat(t)); end
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL basic_data t%0d got=%h exp=deadbeef", t, rd); end
    end
  endtask

  task automatic test_byte_lanes();
    int lat; bit ak, er, both; logic [31:0] rd;
    xfer(0, 1, 32'h40, 32'h11223344, 4'hF, lat, ak, er, rd, both);
    xfer(0, 1, 32'h40, 32'hAABBCCDD, 4'h5, lat, ak, er, rd, both);
    xfer(0, 1, 32'h40, 32'h55555555, 4'h0, lat, ak, er, rd, both);
    n_checks++; if (!ak) begin n_errors++; $display("FAIL sel0_write_ack got=%b exp=1", ak); end
    xfer(0, 0, 32'h42, 32'h0, 4'h0, lat, ak, er, rd, both);
    n_checks++; if (!ak) begin n_errors++; $display("FAIL sel0_read_ack got=%b exp=1", ak); end
    n_checks++; if (rd !== 32'h11BB33DD) begin n_errors++; $display("FAIL byte_lanes got=%h exp=11bb33dd", rd); end
    model[0][16] = 32'h11BB33DD;
  endtask

  task automatic fill();
    int lat; bit ak, er, both; logic [31:0] rd, d;
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        xfer(t, 1, 32'(i * 4), d, 4'hF, lat, ak, er, rd, both);
        model_write(t, 32'(i * 4), d, 4'hF);
      end
  endtask

  task automatic test_random();
    int lat, t; bit ak, er, both, w; logic [31:0] rd, a, d; logic [3:0] s;
    for (int n = 0; n < 60; n++) begin
      t = $urandom_range(0, 1); w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom; s = 4'($urandom);
      xfer(t, w, a, d, s, lat, ak, er, rd, both);
      n_checks++; if (!ak || er || both || lat != exp_lat(t)) begin n_errors++;
        $display("FAIL rand_term n%0d t%0d got ack=%b err=%b lat=%0d exp ack=1 err=0 lat=%0d", n, t, ak, er, lat, exp_lat(t)); end
      if (w) model_write(t, a, d, s);
      else begin
        n_checks++; if (rd !== model[t][widx(a)]) begin n_errors++;
          $display("FAIL rand_data n%0d t%0d adr=%h got=%h exp=%h", n, t, a, rd, model[t][widx(a)]); end
      end
    end
  endtask

  task automatic test_oob();
    int lat; bit ak, er, both; logic [31:0] rd;
    logic [31:0] v = 32'hC0FFEE01;
    bit ob = is_oob(32'h400);
    xfer(0, 1, 32'h400, v, 4'hF, lat, ak, er, rd, both);
    n_checks++; if (ak !== !ob || er !== ob || both || lat != 2) begin n_errors++;
      $display("FAIL oob_wr got ack=%b err=%b lat=%0d exp ack=%b err=%b lat=2", ak, er, lat, !ob, ob); end
    if (ob) begin
      n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL oob_wr_dat got=%h exp=0", rd); end
    end
    model_write(0, 32'h400, v, 4'hF);
    xfer(0, 0, 32'h0, 32'h0, 4'hF, lat, ak, er, rd, both);
    n_checks++; if (rd !== model[0][0]) begin n_errors++; $display("FAIL oob_word0 got=%h exp=%h", rd, model[0][0]); end
    xfer(0, 0, 32'h400, 32'h0, 4'hF, lat, ak, er, rd, both);
    n_checks++; if (rd !== (ob ? 32'h0 : model[0][0]) || er !== ob) begin n_errors++;
      $display("FAIL oob_rd got dat=%h err=%b exp dat=%h err=%b", rd, er, ob ? 32'h0 : model[0][0], ob); end
  endtask

  task automatic test_abort();
    int lat, seen; bit ak, er, both; logic [31:0] rd;
    xfer(1, 1, 32'h30, 32'h0BADF00D, 4'hF, lat, ak, er, rd, both);
    model_write(1, 32'h30, 32'h0BADF00D, 4'hF);
    @(negedge clock);
    tgt = 1; we = 1; adr = 32'h30; dat_w = 32'h12345678; sel = 4'hF; cyc = 1; stb = 1;
    repeat (2) @(negedge clock);
    cyc = 0; stb = 0;
    seen = 0;
    repeat (8) begin @(negedge clock); if (ack_o || err_o) seen++; end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL abort_term got=%0d pulses exp=0", seen); end
    // stb without cyc must be ignored
    stb = 1; seen = 0;
    repeat (8) begin @(negedge clock); if (ack_o || err_o) seen++; end
    stb = 0;
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL stb_no_cyc got=%0d pulses exp=0", seen); end
    xfer(1, 0, 32'h30, 32'h0, 4'hF, lat, ak, er, rd, both);
    n_checks++; if (rd !== 32'h0BADF00D) begin n_errors++; $display("FAIL abort_data got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_reset_mid();
    int lat, seen; bit ak, er, both; logic [31:0] rd;
    logic [31:0] pre = $urandom | 32'h1;
    xfer(1, 1, 32'h20, pre, 4'hF, lat, ak, er, rd, both);
    model_write(1, 32'h20, pre, 4'hF);
    xfer(1, 0, 32'h20, 32'h0, 4'hF, lat, ak, er, rd, both);
    @(negedge clock);
    tgt = 1; we = 1; adr = 32'h20; dat_w = ~pre; sel = 4'hF; cyc = 1; stb = 1;
    repeat (2) @(negedge clock);
    reset = 0; #1;
    n_checks++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin n_errors++;
      $display("FAIL rst_mid_term got ack=%b err=%b exp 0 0", ack_o, err_o); end
    n_checks++; if (dat_r_o !== 32'h0) begin n_errors++; $display("FAIL rst_mid_dat_r got=%h exp=0", dat_r_o); end
    repeat (2) @(negedge clock);
    cyc = 0; stb = 0; reset = 1; seen = 0;
    repeat (8) begin @(negedge clock); if (ack_o || err_o) seen++; end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL rst_mid_late got=%0d pulses exp=0", seen); end
    xfer(1, 0, 32'h20, 32'h0, 4'hF, lat, ak, er, rd, both);
    n_checks++; if (rd !== pre) begin n_errors++; $display("FAIL rst_mid_data got=%h exp=%h", rd, pre); end
  endtask

  task automatic test_back_to_back();
    int k, last, gap;
    for (int t = 0; t < 2; t++) begin
      k = 0; last = -1; gap = 3 + (t == 1 ? 3 : 0);
      @(negedge clock);
      tgt = t; we = 0; sel = 4'hF; adr = 32'h4; cyc = 1; stb = 1;
      for (int i = 0; i < 80 && k < 4; i++) begin
        @(negedge clock);
        n_checks++; if (ack_o && err_o) begin n_errors++; $display("FAIL b2b_excl t%0d both high", t); end
        if (ack_o) begin
          n_checks++; if (dat_r_o !== model[t][1 + k]) begin n_errors++;
            $display("FAIL b2b_data t%0d k%0d got=%h exp=%h", t, k, dat_r_o, model[t][1 + k]); end
          if (k > 0) begin
            n_checks++; if (i - last != gap) begin n_errors++;
              $display("FAIL b2b_gap t%0d k%0d got=%0d exp=%0d", t, k, i - last, gap); end
          end
          last = i; k++;
          adr = 32'(4 * (k + 1));
          if (k == 4) begin cyc = 0; stb = 0; end
        end
      end
      cyc = 0; stb = 0;
      n_checks++; if (k != 4) begin n_errors++; $display("FAIL b2b_count t%0d got=%0d exp=4", t, k); end
    end
  endtask

  initial begin
    for (int t = 0; t < 2; t++) for (int i = 0; i < 256; i++) model[t][i] = '0;
    test_reset();
    test_basic();
    test_byte_lanes();
    fill();
    test_random();
    test_oob();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
